// File: rtl/frv_fsh_unit.sv
// Funnel-shift unit for fsl/fsr/fsri: result = ROR64({rs1,rs3}, amt)[63:32].
// Iterative by default; define FRV_FSH_FAST_EN for a single-cycle barrel rotate.
module frv_fsh_unit #(
  parameter int unsigned STEP = 8
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        valid,
  input  logic        flush,
  input  logic        op_fsl,
  input  logic [5:0]  shamt,
  input  logic [31:0] rs1,
  input  logic [31:0] rs3,
  output logic        ready,
  output logic [31:0] result,
  output logic        busy
);

  // Left funnel shift is a right rotate by the complement distance.
  logic [5:0] amt_d;
  assign amt_d = op_fsl ? 6'(7'd64 - {1'b0, shamt}) : shamt;

`ifdef FRV_FSH_FAST_EN

  // Upper word of the rotate is the 32-bit window starting amt+32 into {src,src}.
  logic [31:0] rot_hi_d;
  assign rot_hi_d = 32'({rs1, rs3, rs1, rs3} >> (7'd32 + 7'(amt_d)));

  assign ready  = valid & ~flush;
  assign result = ready ? rot_hi_d : 32'd0;
  assign busy   = 1'b0;

`else

  localparam logic [5:0] STEP_W = 6'(STEP);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e      state_q;
  logic [63:0] acc_q;
  logic [5:0]  rem_q;

  logic [5:0]  step_d;
  logic [63:0] rot_d;

  assign step_d = (rem_q > STEP_W) ? STEP_W : rem_q;
  assign rot_d  = 64'({acc_q, acc_q} >> step_d);

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= S_IDLE;
      acc_q   <= 64'd0;
      rem_q   <= 6'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid && !flush) begin
            acc_q   <= {rs1, rs3};
            rem_q   <= amt_d;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Completion or flush both drop back to IDLE; flush just hides ready.
          if (flush || (rem_q == 6'd0)) begin
            state_q <= S_IDLE;
          end else begin
            acc_q <= rot_d;
            rem_q <= rem_q - step_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state_q == S_BUSY);
  assign ready  = busy & (rem_q == 6'd0) & ~flush;
  assign result = ready ? acc_q[63:32] : 32'd0;

`endif

endmodule

// File: tb/tb_frv_fsh_unit.sv
// Directed self-checking bench for frv_fsh_unit (STEP=8); honours FRV_FSH_FAST_EN.
module tb_frv_fsh_unit;

  logic        g_clk;
  logic        g_reset;
  logic        valid;
  logic        flush;
  logic        op_fsl;
  logic [5:0]  shamt;
  logic [31:0] rs1;
  logic [31:0] rs3;
  logic        ready;
  logic [31:0] result;
  logic        busy;

  int n_vec;
  int n_err;

  frv_fsh_unit #(.STEP(8)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .valid   (valid),
    .flush   (flush),
    .op_fsl  (op_fsl),
    .shamt   (shamt),
    .rs1     (rs1),
    .rs3     (rs3),
    .ready   (ready),
    .result  (result),
    .busy    (busy)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_op(input logic fsl, input logic [5:0] sh,
                        input logic [31:0] a, input logic [31:0] b);
    op_fsl = fsl;
    shamt  = sh;
    rs1    = a;
    rs3    = b;
    valid  = 1'b1;
  endtask

  // Counts edges from the accept edge until ready; operands are scrambled after accept.
  task automatic wait_ready(input string tag, input int lat, input logic [31:0] exp);
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
      if (cnt == 1) begin
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        if (lat > 1) chk({tag, "_res_idle0"}, result, 32'd0);
        rs1    = ~rs1;
        rs3    = rs3 ^ 32'h5A5A_A5A5;
        shamt  = ~shamt;
        op_fsl = ~op_fsl;
      end
    end while (!ready && cnt < 40);
    chk({tag, "_lat"}, 32'(cnt), 32'(lat));
    chk({tag, "_res"}, result, exp);
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    g_reset = 1'b1;
    valid   = 1'b0;
    flush   = 1'b0;
    op_fsl  = 1'b0;
    shamt   = 6'd0;
    rs1     = 32'd0;
    rs3     = 32'd0;
    step();
    step();
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'd0);
    g_reset = 1'b0;
    step();

`ifdef FRV_FSH_FAST_EN
    set_op(1'b0, 6'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    chk("f1_ready", 32'(ready), 32'd1);
    chk("f1_res", result, 32'hF012_3456);
    chk("f1_busy", 32'(busy), 32'd0);
    set_op(1'b0, 6'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    chk("f2_res", result, 32'h1234_5678);
    set_op(1'b0, 6'd63, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    chk("f3_res", result, 32'h2468_ACF1);
    set_op(1'b1, 6'd4, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    chk("f4_res", result, 32'h2345_6789);
    set_op(1'b0, 6'd16, 32'hDEAD_BEEF, 32'h0123_4567);
    #1;
    chk("f5_res", result, 32'h4567_DEAD);
    flush = 1'b1;
    #1;
    chk("f6_flush_ready", 32'(ready), 32'd0);
    chk("f6_flush_res", result, 32'd0);
    flush = 1'b0;
    valid = 1'b0;
    #1;
    chk("f7_novalid", 32'(ready), 32'd0);
    step();
`else
    // Vector 1: fsr 8
    set_op(1'b0, 6'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("v1", 2, 32'hF012_3456);
    valid = 1'b0;
    step();
    chk("v1_after_busy", 32'(busy), 32'd0);
    chk("v1_after_res", result, 32'd0);

    // Vector 2: fsr 0, busy only in the ready cycle
    set_op(1'b0, 6'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("v2", 1, 32'h1234_5678);
    valid = 1'b0;
    step();
    chk("v2_after_busy", 32'(busy), 32'd0);

    // Vector 3: fsr 63
    set_op(1'b0, 6'd63, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("v3", 9, 32'h2468_ACF1);
    valid = 1'b0;
    step();

    // Vector 4: fsl 4, then back-to-back fsr 16 with valid held
    set_op(1'b1, 6'd4, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("v4", 9, 32'h2345_6789);
    set_op(1'b0, 6'd16, 32'hDEAD_BEEF, 32'h0123_4567);
    step();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_ready", 32'(ready), 32'd0);
    wait_ready("b2b", 3, 32'h4567_DEAD);
    valid = 1'b0;
    step();

    // Vector 5: flush mid-op, then new op right after
    set_op(1'b0, 6'd63, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    step();
    step();
    flush = 1'b1;
    #1;
    chk("v5_flush_ready", 32'(ready), 32'd0);
    step();
    flush = 1'b0;
    chk("v5_post_busy", 32'(busy), 32'd0);
    chk("v5_post_ready", 32'(ready), 32'd0);
    set_op(1'b0, 6'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_ready("v5_new", 2, 32'hF012_3456);
    valid = 1'b0;
    step();

    // Flush coinciding with rem==0 hides the ready pulse
    set_op(1'b0, 6'd0, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    valid = 1'b0;
    flush = 1'b1;
    #1;
    chk("fz_ready", 32'(ready), 32'd0);
    chk("fz_res", result, 32'd0);
    step();
    flush = 1'b0;
    chk("fz_after_busy", 32'(busy), 32'd0);

    // Flush in IDLE blocks acceptance
    set_op(1'b0, 6'd8, 32'h1234_5678, 32'h9ABC_DEF0);
    flush = 1'b1;
    step();
    chk("fidle_busy", 32'(busy), 32'd0);
    flush = 1'b0;
    valid = 1'b0;
    step();

    // Async reset mid-op
    set_op(1'b0, 6'd63, 32'h1234_5678, 32'h9ABC_DEF0);
    step();
    valid = 1'b0;
    step();
    step();
    step();
    step();
    chk("rmid_busy_pre", 32'(busy), 32'd1);
    g_reset = 1'b1;
    #1;
    chk("rmid_busy", 32'(busy), 32'd0);
    chk("rmid_ready", 32'(ready), 32'd0);
    step();
    g_reset = 1'b0;
    step();
    chk("rmid_after_busy", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
